// File: rtl/fifo_pkg.sv
// Shared constants and types for the synchronous FIFO, its stream reader and the benches.
package fifo_pkg;

    localparam int unsigned DATA_W     = 8;
    localparam int unsigned BEAT_CNT_W = 16;

    // Output buffer occupancy, 0..2.
    typedef logic [1:0] occ_t;

    localparam occ_t OCC_MAX = 2'd2;

endpackage

// File: rtl/fifo_stream_reader_if.sv
// FIFO read port plus valid/ready stream; master is the reader, slave is the FIFO/sink side.
interface fifo_stream_reader_if
    import fifo_pkg::*;
#(
    parameter int unsigned WIDTH = DATA_W
);

    logic             fifo_empty;
    logic [WIDTH-1:0] fifo_data;
    logic             fifo_rd_en;
    logic             m_valid;
    logic             m_ready;
    logic [WIDTH-1:0] m_data;

    modport master (
        input  fifo_empty,
        input  fifo_data,
        input  m_ready,
        output fifo_rd_en,
        output m_valid,
        output m_data
    );

    modport slave (
        output fifo_empty,
        output fifo_data,
        output m_ready,
        input  fifo_rd_en,
        input  m_valid,
        input  m_data
    );

endinterface

// File: rtl/fifo_skid_buf.sv
// Two-entry circular buffer with push, pop and synchronous flush; exposes occupancy and head.
module fifo_skid_buf
    import fifo_pkg::*;
#(
    parameter int unsigned WIDTH = DATA_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    input  logic             flush_i,
    output occ_t             occ_o,
    output logic [WIDTH-1:0] head_data_o
);

    logic [WIDTH-1:0] mem_q [2];
    occ_t             occ_q, occ_d;
    logic             head_q, head_d;
    logic             tail_q, tail_d;

    always_comb begin
        occ_d  = occ_q;
        head_d = head_q;
        tail_d = tail_q;
        if (flush_i) begin
            occ_d  = '0;
            head_d = 1'b0;
            tail_d = 1'b0;
        end else begin
            if (push_i) tail_d = ~tail_q;
            if (pop_i)  head_d = ~head_q;
            occ_d = occ_q + occ_t'(push_i) - occ_t'(pop_i);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            occ_q    <= '0;
            head_q   <= 1'b0;
            tail_q   <= 1'b0;
            mem_q[0] <= '0;
            mem_q[1] <= '0;
        end else begin
            occ_q  <= occ_d;
            head_q <= head_d;
            tail_q <= tail_d;
            if (push_i && !flush_i) mem_q[tail_q] <= push_data_i;
        end
    end

    assign occ_o       = occ_q;
    assign head_data_o = mem_q[head_q];

endmodule

// File: rtl/fifo_stream_reader.sv
// Reads a registered-output FIFO and re-presents its data as a full-throughput valid/ready stream.
module fifo_stream_reader
    import fifo_pkg::*;
#(
    parameter int unsigned WIDTH = DATA_W,
    parameter int unsigned CNT_W = BEAT_CNT_W
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic                 flush,
    fifo_stream_reader_if.master bus,
    output logic [CNT_W-1:0]     beat_cnt,
    output logic                 idle
);

    occ_t             occ;
    logic [WIDTH-1:0] head_data;
    logic             pop;
    logic             push;
    logic             rd_en;
    logic [2:0]       pending;
    logic             in_flight_q, in_flight_d;
    logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;

    assign pop  = bus.m_valid && bus.m_ready;
    // An in-flight datum always lands; the issue rule below reserves its slot.
    assign push = in_flight_q && !flush;

    // Counting this cycle's pop lets a full buffer refill every cycle.
    assign pending = 3'(occ) + 3'(in_flight_q) - 3'(pop);

    always_comb begin
        rd_en       = !reset && !flush && enable && !bus.fifo_empty && (pending < 3'(OCC_MAX));
        in_flight_d = rd_en;
        beat_cnt_d  = beat_cnt_q;
        if (pop) beat_cnt_d = beat_cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            in_flight_q <= 1'b0;
            beat_cnt_q  <= '0;
        end else begin
            in_flight_q <= in_flight_d;
            beat_cnt_q  <= beat_cnt_d;
        end
    end

    fifo_skid_buf #(
        .WIDTH (WIDTH)
    ) u_buf (
        .clk         (clk),
        .reset       (reset),
        .push_i      (push),
        .push_data_i (bus.fifo_data),
        .pop_i       (pop),
        .flush_i     (flush),
        .occ_o       (occ),
        .head_data_o (head_data)
    );

    assign bus.fifo_rd_en = rd_en;
    assign bus.m_valid    = (occ != '0);
    assign bus.m_data     = head_data;
    assign beat_cnt       = beat_cnt_q;
    assign idle           = (occ == '0) && !in_flight_q;

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Self-checking bench: FIFO emulation, queue-based reference model, directed and random scenarios.
module tb_fifo_stream_reader;
    import fifo_pkg::*;

    localparam int unsigned W  = DATA_W;
    localparam int unsigned CW = 4;

    logic          clk = 1'b0;
    logic          reset, enable, flush;
    logic [CW-1:0] beat_cnt;
    logic          idle;

    fifo_stream_reader_if #(.WIDTH(W)) bus ();

    fifo_stream_reader #(
        .WIDTH (W),
        .CNT_W (CW)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .enable   (enable),
        .flush    (flush),
        .bus      (bus),
        .beat_cnt (beat_cnt),
        .idle     (idle)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    logic [W-1:0] fq[$];     // FIFO contents
    logic [W-1:0] mq[$];     // model: data visible to the stream, head first
    logic [W-1:0] log_q[$];  // every beat the DUT handed over
    bit           m_inf;
    logic [W-1:0] m_inf_d;
    int           m_cnt;

    logic         s_rd, s_valid, s_pop, s_idle;
    logic [W-1:0] s_data;
    int           s_cnt;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    task automatic fifo_push(input logic [W-1:0] d);
        fq.push_back(d);
        bus.fifo_empty = 1'b0;
    endtask

    // Called just after a falling edge with inputs already set; returns at the next falling edge.
    task automatic tick();
        logic         exp_valid, exp_pop, exp_rd, rd;
        logic [W-1:0] nd;
        #1;
        exp_valid = (mq.size() != 0);
        exp_pop   = exp_valid && bus.m_ready;
        exp_rd    = !reset && !flush && enable && !bus.fifo_empty
                    && (int'(mq.size()) + int'(m_inf) - int'(exp_pop) < 2);
        check_eq("m_valid", 32'(bus.m_valid), 32'(exp_valid));
        if (exp_valid) check_eq("m_data", 32'(bus.m_data), 32'(mq[0]));
        check_eq("fifo_rd_en", 32'(bus.fifo_rd_en), 32'(exp_rd));
        check_eq("idle", 32'(idle), 32'(mq.size() == 0 && !m_inf));
        check_eq("beat_cnt", 32'(beat_cnt), 32'(m_cnt % (1 << CW)));
        check_eq("no_overflow", 32'(dut.u_buf.occ_o <= OCC_MAX), 32'd1);
        s_rd    = bus.fifo_rd_en;
        s_valid = bus.m_valid;
        s_pop   = bus.m_valid && bus.m_ready;
        s_idle  = idle;
        s_data  = bus.m_data;
        s_cnt   = int'(beat_cnt);
        rd      = bus.fifo_rd_en;
        if (s_pop === 1'b1) log_q.push_back(bus.m_data);
        nd = '0;
        if (rd === 1'b1 && fq.size() > 0) nd = fq.pop_front();
        @(posedge clk);
        #1;
        if (rd === 1'b1) bus.fifo_data = nd;
        bus.fifo_empty = (fq.size() == 0);
        if (reset) begin
            mq.delete();
            m_inf = 1'b0;
            m_cnt = 0;
        end else if (flush) begin
            if (exp_pop) m_cnt++;
            mq.delete();
            m_inf = 1'b0;
        end else begin
            if (exp_pop) begin
                void'(mq.pop_front());
                m_cnt++;
            end
            if (m_inf) mq.push_back(m_inf_d);
            m_inf   = exp_rd;
            m_inf_d = nd;
        end
        @(negedge clk);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        int fr, fv, first_pop, last_pop, nrd, npop, mark, c0, any_rd, any_v, any_busy;
        bit saw15, wrapped;
        int prev;

        reset          = 1'b1;
        enable         = 1'b0;
        flush          = 1'b0;
        bus.m_ready    = 1'b0;
        bus.fifo_empty = 1'b1;
        bus.fifo_data  = '0;
        m_inf          = 1'b0;
        m_inf_d        = '0;
        m_cnt          = 0;
        @(posedge clk);
        @(negedge clk);

        // Reset state
        tick();
        check_eq("rst_m_data", 32'(s_data), 32'd0);
        check_eq("rst_idle", 32'(s_idle), 32'd1);
        check_eq("rst_valid", 32'(s_valid), 32'd0);

        // Basic latency and ordering
        reset = 1'b0;
        enable = 1'b1;
        bus.m_ready = 1'b1;
        fifo_push(8'h11); fifo_push(8'h22); fifo_push(8'h33);
        mark = log_q.size();
        fr = -1; fv = -1; first_pop = -1; last_pop = -1;
        for (int k = 0; k < 8; k++) begin
            tick();
            if (s_rd && fr < 0) fr = k;
            if (s_valid && fv < 0) fv = k;
            if (s_pop) begin
                if (first_pop < 0) first_pop = k;
                last_pop = k;
            end
        end
        check_eq("lat_first_rd", 32'(fr), 32'd0);
        check_eq("lat_first_valid", 32'(fv - fr), 32'd2);
        check_eq("lat_back_to_back", 32'(last_pop - first_pop), 32'd2);
        check_eq("lat_beats", 32'(log_q.size() - mark), 32'd3);
        if (log_q.size() - mark == 3) begin
            check_eq("lat_d0", 32'(log_q[mark]), 32'h11);
            check_eq("lat_d1", 32'(log_q[mark+1]), 32'h22);
            check_eq("lat_d2", 32'(log_q[mark+2]), 32'h33);
        end
        check_eq("lat_cnt", 32'(s_cnt), 32'd3);
        check_eq("lat_idle", 32'(s_idle), 32'd1);

        // Backpressure
        bus.m_ready = 1'b0;
        for (int i = 0; i < 4; i++) fifo_push(8'hA0 + 8'(i));
        nrd = 0;
        for (int k = 0; k < 6; k++) begin
            tick();
            nrd += int'(s_rd);
        end
        check_eq("bp_reads", 32'(nrd), 32'd2);
        check_eq("bp_occ", 32'(dut.u_buf.occ_o), 32'd2);
        check_eq("bp_head", 32'(s_data), 32'hA0);
        bus.m_ready = 1'b1;
        mark = log_q.size();
        npop = 0;
        for (int k = 0; k < 4; k++) begin
            tick();
            npop += int'(s_pop);
        end
        check_eq("bp_no_gap", 32'(npop), 32'd4);
        for (int i = 0; i < 4; i++)
            if (log_q.size() > mark + i) check_eq("bp_order", 32'(log_q[mark+i]), 32'hA0 + i);
        run(3);

        // Empty boundary
        any_rd = 0; any_v = 0; any_busy = 0;
        for (int k = 0; k < 10; k++) begin
            tick();
            any_rd += int'(s_rd);
            any_v  += int'(s_valid);
            any_busy += int'(!s_idle);
        end
        check_eq("empty_rd", 32'(any_rd), 32'd0);
        check_eq("empty_valid", 32'(any_v), 32'd0);
        check_eq("empty_busy", 32'(any_busy), 32'd0);
        mark = log_q.size();
        fifo_push(8'h5A);
        run(6);
        check_eq("single_beats", 32'(log_q.size() - mark), 32'd1);
        if (log_q.size() > mark) check_eq("single_data", 32'(log_q[mark]), 32'h5A);

        // Flush with one buffered and one in flight
        bus.m_ready = 1'b0;
        fifo_push(8'h10);
        run(4);
        fifo_push(8'h20); fifo_push(8'h30);
        tick();
        check_eq("fl_rd_issued", 32'(s_rd), 32'd1);
        flush = 1'b1;
        tick();
        check_eq("fl_rd_forced", 32'(s_rd), 32'd0);
        c0 = s_cnt;
        flush = 1'b0;
        bus.m_ready = 1'b1;
        mark = log_q.size();
        run(8);
        check_eq("fl_beats", 32'(log_q.size() - mark), 32'd1);
        if (log_q.size() > mark) check_eq("fl_data", 32'(log_q[mark]), 32'h30);
        check_eq("fl_cnt", 32'(s_cnt), 32'((c0 + 1) % (1 << CW)));

        // Reset mid-stream with data buffered and a read in flight
        bus.m_ready = 1'b0;
        fifo_push(8'hB0); fifo_push(8'hB1); fifo_push(8'hB2);
        run(2);
        reset = 1'b1;
        tick();
        tick();
        check_eq("mr_valid", 32'(s_valid), 32'd0);
        check_eq("mr_cnt", 32'(s_cnt), 32'd0);
        check_eq("mr_idle", 32'(s_idle), 32'd1);
        check_eq("mr_rd", 32'(s_rd), 32'd0);
        check_eq("mr_data", 32'(s_data), 32'd0);
        reset = 1'b0;
        bus.m_ready = 1'b1;
        mark = log_q.size();
        run(6);
        check_eq("mr_beats", 32'(log_q.size() - mark), 32'd1);
        if (log_q.size() > mark) check_eq("mr_survivor", 32'(log_q[mark]), 32'hB2);

        // Counter wrap over 17 beats from zero
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int i = 0; i < 17; i++) fifo_push(8'(i * 7));
        saw15 = 1'b0; wrapped = 1'b0; prev = 0;
        for (int k = 0; k < 25; k++) begin
            tick();
            if (s_cnt == 15) saw15 = 1'b1;
            if (prev == 15 && s_cnt == 0) wrapped = 1'b1;
            prev = s_cnt;
        end
        check_eq("wrap_saw15", 32'(saw15), 32'd1);
        check_eq("wrap_15_to_0", 32'(wrapped), 32'd1);
        check_eq("wrap_final", 32'(s_cnt), 32'd1);

        // Random traffic
        for (int k = 0; k < 400; k++) begin
            enable      = ($urandom_range(0, 3) != 0);
            bus.m_ready = ($urandom_range(0, 9) < 7);
            flush       = ($urandom_range(0, 31) == 0);
            if (fq.size() < 16 && $urandom_range(0, 1) == 1) fifo_push(8'($urandom));
            tick();
        end
        enable = 1'b1;
        bus.m_ready = 1'b1;
        flush = 1'b0;
        run(40);
        check_eq("rand_drained", 32'(fq.size()), 32'd0);
        check_eq("rand_idle", 32'(s_idle), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
